// File: rtl/prover_addtree_pkg.sv
// Shared definitions for the prover add tree: field parameters, FSM states
// and helpers that derive the tree depth and in-flight counter width.
package prover_addtree_pkg;

   localparam int F_NBITS = 16;
   localparam logic [F_NBITS-1:0] F_PRIME = 16'd65521;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_CLR
   } addt_state_t;

   function automatic int addt_depth(input int npoints);
      return npoints - 1;
   endfunction

   // Counter must hold every vector that can be inside the D-stage pipe.
   function automatic int addt_cnt_w(input int npoints);
      return $clog2(addt_depth(npoints) + 2);
   endfunction

endpackage

// File: rtl/field_adder.sv
// Combinational modular adder: s = (a + b) mod F_PRIME, operands assumed < F_PRIME.
module field_adder
   import prover_addtree_pkg::*;
(
   input  logic [F_NBITS-1:0] a,
   input  logic [F_NBITS-1:0] b,
   output logic [F_NBITS-1:0] s
);

   logic [F_NBITS:0]   raw;
   logic [F_NBITS-1:0] red;

   // The reduced value always fits F_NBITS bits, so a wrapping subtract suffices.
   always_comb begin
      raw = {1'b0, a} + {1'b0, b};
      red = raw[F_NBITS-1:0] - F_PRIME;
      s   = (raw >= {1'b0, F_PRIME}) ? red : raw[F_NBITS-1:0];
   end

endmodule

// File: rtl/prover_shared_addtree.sv
// Pipelined modular add tree feeding two tagged accumulators.
// Define PROVER_ADDTREE_ACC_EN to accumulate; otherwise each result overwrites.
module prover_shared_addtree
   import prover_addtree_pkg::*;
#(
   parameter int npoints = 3
) (
   input  logic               clk,
   input  logic               rstb,
   input  logic               addt_en,
   input  logic               addt_tag,
   input  logic [F_NBITS-1:0] vals_in [1 << (npoints-1)],
   input  logic               clr,
   output logic               addt_ready,
   output logic [F_NBITS-1:0] sum_out [2],
   output logic               done_pulse,
   output logic               idle
);

   localparam int ngates = 1 << (npoints-1);
   localparam int D      = addt_depth(npoints);
   localparam int CW     = addt_cnt_w(npoints);

   if (npoints < 2) begin : g_bad_npoints
      $error("prover_shared_addtree: npoints must be at least 2");
   end

   logic               accept;
   logic               out_valid;
   logic [CW-1:0]      cnt;
   logic [CW-1:0]      cnt_next;
   logic               clr_pending;
   addt_state_t        state;
   addt_state_t        state_next;
   logic [F_NBITS-1:0] node_sum [1:ngates-1];
   logic [F_NBITS-1:0] tree_q   [1:ngates-1];
   logic               valid_q  [1:D];
   logic               tag_q    [1:D];
   logic [F_NBITS-1:0] tree_res;
   logic [F_NBITS-1:0] acc_next [2];

   assign accept    = addt_en & addt_ready;
   assign out_valid = valid_q[D];
   assign cnt_next  = cnt + CW'(accept) - CW'(out_valid);
   assign tree_res  = tree_q[1];

   // Heap-indexed tree: node i sums children 2i and 2i+1; indices >= ngates are input lanes.
   for (genvar i = 1; i < ngates; i++) begin : g_node
      logic [F_NBITS-1:0] lhs;
      logic [F_NBITS-1:0] rhs;
      if (2*i >= ngates) begin : g_leaf
         assign lhs = vals_in[2*i - ngates];
         assign rhs = vals_in[2*i + 1 - ngates];
      end else begin : g_inner
         assign lhs = tree_q[2*i];
         assign rhs = tree_q[2*i + 1];
      end
      field_adder u_add (.a(lhs), .b(rhs), .s(node_sum[i]));
   end

   always_ff @(posedge clk) begin
      tree_q <= node_sum;
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         for (int k = 1; k <= D; k++) begin
            valid_q[k] <= 1'b0;
            tag_q[k]   <= 1'b0;
         end
      end else begin
         valid_q[1] <= accept;
         tag_q[1]   <= addt_tag;
         for (int k = 2; k <= D; k++) begin
            valid_q[k] <= valid_q[k-1];
            tag_q[k]   <= tag_q[k-1];
         end
      end
   end

`ifdef PROVER_ADDTREE_ACC_EN
   for (genvar j = 0; j < 2; j++) begin : g_acc
      field_adder u_acc (.a(sum_out[j]), .b(tree_res), .s(acc_next[j]));
   end
`else
   assign acc_next[0] = tree_res;
   assign acc_next[1] = tree_res;
`endif

   // A clear cycle takes priority over a tree result landing in the same cycle.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         sum_out[0] <= '0;
         sum_out[1] <= '0;
      end else if (state == ST_CLR) begin
         sum_out[0] <= '0;
         sum_out[1] <= '0;
      end else if (out_valid) begin
         sum_out[tag_q[D]] <= acc_next[tag_q[D]];
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         cnt         <= '0;
         clr_pending <= 1'b0;
         done_pulse  <= 1'b0;
      end else begin
         cnt        <= cnt_next;
         done_pulse <= (cnt != '0) && (cnt_next == '0);
         if (state == ST_CLR)
            clr_pending <= 1'b0;
         else if (clr && ((state == ST_BUSY) || accept))
            clr_pending <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb)
         state <= ST_IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (accept)
               state_next = ST_BUSY;
            else if (clr || clr_pending)
               state_next = ST_CLR;
         end
         ST_BUSY: begin
            if (cnt_next == '0)
               state_next = ST_IDLE;
         end
         ST_CLR:  state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      addt_ready = ~clr_pending & (state != ST_CLR);
      idle       = (state == ST_IDLE) & ~clr_pending & ~clr;
   end

endmodule

// File: tb/tb_prover_shared_addtree.sv
// Scoreboard bench for prover_shared_addtree: directed corner cases plus random
// vectors, with expected sums computed arithmetically from the accepted lanes.
module tb_prover_shared_addtree;
   import prover_addtree_pkg::*;

   localparam int NPOINTS = 3;
   localparam int NG      = 1 << (NPOINTS-1);
   localparam int D       = NPOINTS - 1;
   localparam longint P   = longint'(F_PRIME);

   typedef struct {
      int     due;
      bit     tag;
      longint val;
   } exp_t;

   logic               clk = 1'b0;
   logic               rstb = 1'b1;
   logic               addt_en = 1'b0;
   logic               addt_tag = 1'b0;
   logic               clr = 1'b0;
   logic [F_NBITS-1:0] vals_in [NG];
   logic               addt_ready;
   logic [F_NBITS-1:0] sum_out [2];
   logic               done_pulse;
   logic               idle;

   logic [F_NBITS-1:0] stim [NG];
   exp_t               sbq[$];
   longint             model_sum [2];
   bit                 acc_mode;
   int                 cyc = 0;
   int                 total = 0;
   int                 bad = 0;

   prover_shared_addtree #(.npoints(NPOINTS)) dut (
      .clk        (clk),
      .rstb       (rstb),
      .addt_en    (addt_en),
      .addt_tag   (addt_tag),
      .vals_in    (vals_in),
      .clr        (clr),
      .addt_ready (addt_ready),
      .sum_out    (sum_out),
      .done_pulse (done_pulse),
      .idle       (idle)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_output(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Drives one cycle of inputs; an accepted vector updates the model and the scoreboard.
   task automatic apply_stimulus(input bit en, input bit tag, input bit clr_in);
      longint s;
      @(negedge clk);
      addt_en  = en;
      addt_tag = tag;
      clr      = clr_in;
      for (int i = 0; i < NG; i++) vals_in[i] = stim[i];
      if (en && addt_ready) begin
         s = 0;
         for (int i = 0; i < NG; i++) s += longint'(stim[i]);
         s = s % P;
         model_sum[tag] = acc_mode ? (model_sum[tag] + s) % P : s;
         sbq.push_back('{due: cyc + D + 1, tag: tag, val: model_sum[tag]});
      end
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      do begin
         apply_stimulus(1'b0, 1'b0, 1'b0);
         #1;
         n++;
      end while (!(idle && sbq.size() == 0) && n < 40);
      check_output({name, "_idle"}, longint'(idle && sbq.size() == 0), 1);
   endtask

   task automatic do_clear(input string name);
      apply_stimulus(1'b0, 1'b0, 1'b1);
      wait_idle(name);
      model_sum = '{0, 0};
      check_output({name, "_sum0"}, sum_out[0], 0);
      check_output({name, "_sum1"}, sum_out[1], 0);
   endtask

   task automatic do_reset(input int hold);
      @(posedge clk);
      #2;
      rstb    = 1'b0;
      addt_en = 1'b0;
      clr     = 1'b0;
      sbq.delete();
      model_sum = '{0, 0};
      repeat (hold) @(negedge clk);
      #1;
      check_output("rst_sum0", sum_out[0], 0);
      check_output("rst_sum1", sum_out[1], 0);
      check_output("rst_done", done_pulse, 0);
      @(posedge clk);
      #2;
      rstb = 1'b1;
      @(negedge clk);
      #1;
      check_output("rst_ready", addt_ready, 1);
      check_output("rst_idle", idle, 1);
   endtask

   // Monitor: retires results on the cycle they must be visible and
   // expects done_pulse exactly when the last in-flight vector has landed.
   always @(negedge clk) begin : monitor
      bit   popped;
      int   infl;
      exp_t e;
      if (rstb) begin
         popped = 1'b0;
         infl   = 0;
         while (sbq.size() > 0 && sbq[0].due == cyc) begin
            e = sbq.pop_front();
            check_output(e.tag ? "sb_sum1" : "sb_sum0", sum_out[e.tag], e.val);
            popped = 1'b1;
         end
         foreach (sbq[k]) if (sbq[k].due - D - 1 < cyc) infl++;
         check_output("done_pulse", done_pulse, longint'(popped && infl == 0));
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
`ifdef PROVER_ADDTREE_ACC_EN
      acc_mode = 1'b1;
`else
      acc_mode = 1'b0;
`endif
      model_sum = '{0, 0};
      stim = '{0, 0, 0, 0};
      for (int i = 0; i < NG; i++) vals_in[i] = '0;
      #1 rstb = 1'b0;
      do_reset(3);

      stim = '{1, 2, 3, 4};
      apply_stimulus(1'b1, 1'b0, 1'b0);
      wait_idle("single");
      check_output("single_sum0", sum_out[0], 10);

      stim = '{1, 1, 1, 1};
      apply_stimulus(1'b1, 1'b1, 1'b0);
      stim = '{2, 2, 2, 2};
      apply_stimulus(1'b1, 1'b1, 1'b0);
      wait_idle("same_tag");
      check_output("same_tag_sum1", sum_out[1], acc_mode ? 12 : 8);
      do_clear("clear1");

      stim = '{F_PRIME - 1, F_PRIME - 1, F_PRIME - 1, F_PRIME - 1};
      apply_stimulus(1'b1, 1'b0, 1'b0);
      wait_idle("wrap");
      check_output("wrap_sum0", sum_out[0], P - 4);

      stim = '{5, 0, 0, 0};
      apply_stimulus(1'b1, 1'b0, 1'b1);
      apply_stimulus(1'b0, 1'b0, 1'b0);
      #1;
      check_output("clr_blocks_ready", addt_ready, 0);
      wait_idle("clr_accept");
      model_sum = '{0, 0};
      check_output("clr_accept_sum0", sum_out[0], 0);
      check_output("clr_accept_sum1", sum_out[1], 0);
      check_output("clr_accept_ready", addt_ready, 1);

      stim = '{1, 0, 0, 0};
      apply_stimulus(1'b1, 1'b0, 1'b0);
      apply_stimulus(1'b1, 1'b1, 1'b0);
      apply_stimulus(1'b1, 1'b0, 1'b0);
      wait_idle("interleave");
      check_output("interleave_sum0", sum_out[0], acc_mode ? 2 : 1);
      check_output("interleave_sum1", sum_out[1], 1);

      stim = '{7, 8, 9, 10};
      apply_stimulus(1'b1, 1'b0, 1'b0);
      apply_stimulus(1'b1, 1'b1, 1'b0);
      do_reset(2);
      repeat (5) apply_stimulus(1'b0, 1'b0, 1'b0);

      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < NG; i++) stim[i] = F_NBITS'($urandom % 32'(F_PRIME));
         if ($urandom_range(0, 49) == 0) begin
            apply_stimulus(1'b1, 1'($urandom_range(0, 1)), 1'b1);
            do_clear("rand_clear");
         end else begin
            apply_stimulus($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'b0);
         end
      end
      wait_idle("rand_end");
      check_output("rand_end_sum0", sum_out[0], model_sum[0]);
      check_output("rand_end_sum1", sum_out[1], model_sum[1]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
